// File: rtl/dq_pi_ctrl_if.sv
// Handshake and data bundle between the Park stage, the dq PI controller and the inverse-Park stage.
// The master side drives currents, setpoints, gains and strobes; the slave side returns the voltage commands.
interface dq_pi_ctrl_if #(
    parameter int D_WIDTH = 18
);
    logic signed [D_WIDTH-1:0] d_meas;
    logic signed [D_WIDTH-1:0] q_meas;
    logic signed [D_WIDTH-1:0] d_ref;
    logic signed [D_WIDTH-1:0] q_ref;
    logic signed [D_WIDTH-1:0] kp;
    logic signed [D_WIDTH-1:0] ki;
    logic                      start;
    logic                      clear_int;
    logic signed [D_WIDTH-1:0] vd;
    logic signed [D_WIDTH-1:0] vq;
    logic                      busy;
    logic                      done;

    modport master (
        output d_meas, q_meas, d_ref, q_ref, kp, ki, start, clear_int,
        input  vd, vq, busy, done
    );

    modport slave (
        input  d_meas, q_meas, d_ref, q_ref, kp, ki, start, clear_int,
        output vd, vq, busy, done
    );
endinterface

// File: rtl/dq_pi_ctrl.sv
// Dual-axis PI current controller: one shared signed multiplier sequenced through ERR, D_P, D_I, Q_P, Q_I, OUT.
// Define DQ_PI_COND_INT_EN to enable conditional-integration anti-windup.
module dq_pi_ctrl #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15,
    parameter int OUT_LIM = 32767,
    parameter int INT_LIM = 32767
) (
    input logic         clk,
    input logic         rstb,
    dq_pi_ctrl_if.slave bus
);
    localparam int PW = 2 * D_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_DP   = 3'd2;
    localparam logic [2:0] S_DI   = 3'd3;
    localparam logic [2:0] S_QP   = 3'd4;
    localparam logic [2:0] S_QI   = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam logic signed [D_WIDTH:0] E_MAX = {2'b00, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH:0] E_MIN = {2'b11, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    OUT_POS = PW'(OUT_LIM);
    localparam logic signed [PW-1:0]    OUT_NEG = -OUT_POS;
    localparam logic signed [PW-1:0]    INT_POS = PW'(INT_LIM);

    function automatic logic signed [PW-1:0] sx(input logic signed [D_WIDTH-1:0] x);
        return {{(PW-D_WIDTH){x[D_WIDTH-1]}}, x};
    endfunction

    // Error is formed one bit wider so that ref - meas can never wrap before saturation.
    function automatic logic signed [D_WIDTH-1:0] sat_err(input logic signed [D_WIDTH-1:0] r,
                                                          input logic signed [D_WIDTH-1:0] m);
        logic signed [D_WIDTH:0] diff;
        diff = {r[D_WIDTH-1], r} - {m[D_WIDTH-1], m};
        if (diff > E_MAX)
            diff = E_MAX;
        else if (diff < E_MIN)
            diff = E_MIN;
        return D_WIDTH'(diff);
    endfunction

    function automatic logic signed [D_WIDTH-1:0] clamp(input logic signed [PW-1:0] x,
                                                        input logic signed [PW-1:0] lim);
        logic signed [PW-1:0] y;
        if (x > lim)
            y = lim;
        else if (x < -lim)
            y = -lim;
        else
            y = x;
        return D_WIDTH'(y);
    endfunction

    logic [2:0]                state;
    logic                      done_r;
    logic signed [D_WIDTH-1:0] vd_r, vq_r;
    logic signed [D_WIDTH-1:0] int_d, int_q;

    logic signed [D_WIDTH-1:0] d_meas_r, q_meas_r, d_ref_r, q_ref_r, kp_r, ki_r;
    logic signed [D_WIDTH-1:0] e_d, e_q;
    logic signed [PW-1:0]      p_d, p_q;

    logic signed [D_WIDTH-1:0] mul_a, mul_b;
    logic signed [PW-1:0]      product, scaled;
    logic signed [D_WIDTH-1:0] int_old, int_new, int_next;
    logic signed [PW-1:0]      int_sum;
    logic                      hold;

    // The single multiplier sees kp or ki against the error of the axis being processed.
    always_comb begin
        mul_a = kp_r;
        mul_b = e_d;
        case (state)
            S_DP:    begin mul_a = kp_r; mul_b = e_d; end
            S_DI:    begin mul_a = ki_r; mul_b = e_d; end
            S_QP:    begin mul_a = kp_r; mul_b = e_q; end
            S_QI:    begin mul_a = ki_r; mul_b = e_q; end
            default: begin mul_a = kp_r; mul_b = e_d; end
        endcase
    end

    assign product = sx(mul_a) * sx(mul_b);
    assign scaled  = product >>> Q_BITS;

    assign int_old = (state == S_QI) ? int_q : int_d;
    assign int_sum = sx(int_old) + scaled;
    assign int_new = clamp(int_sum, INT_POS);

`ifdef DQ_PI_COND_INT_EN
    logic signed [PW-1:0]      p_cur, u_raw;
    logic signed [D_WIDTH-1:0] e_cur;

    assign p_cur = (state == S_QI) ? p_q : p_d;
    assign e_cur = (state == S_QI) ? e_q : e_d;
    assign u_raw = p_cur + sx(int_old);
    // Stop integrating only when the output is saturated and the error would push it further out.
    assign hold  = ((u_raw > OUT_POS) && !e_cur[D_WIDTH-1] && (e_cur != '0)) ||
                   ((u_raw < OUT_NEG) &&  e_cur[D_WIDTH-1]);
`else
    assign hold  = 1'b0;
`endif

    assign int_next = hold ? int_old : int_new;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
            vd_r   <= '0;
            vq_r   <= '0;
            int_d  <= '0;
            int_q  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.clear_int) begin
                        int_d <= '0;
                        int_q <= '0;
                    end
                    if (bus.start)
                        state <= S_ERR;
                end
                S_ERR: state <= S_DP;
                S_DP:  state <= S_DI;
                S_DI: begin
                    int_d <= int_next;
                    state <= S_QP;
                end
                S_QP:  state <= S_QI;
                S_QI: begin
                    int_q <= int_next;
                    state <= S_OUT;
                end
                S_OUT: begin
                    vd_r   <= clamp(p_d + sx(int_d), OUT_POS);
                    vq_r   <= clamp(p_q + sx(int_q), OUT_POS);
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always written before being consumed.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    d_meas_r <= bus.d_meas;
                    q_meas_r <= bus.q_meas;
                    d_ref_r  <= bus.d_ref;
                    q_ref_r  <= bus.q_ref;
                    kp_r     <= bus.kp;
                    ki_r     <= bus.ki;
                end
            end
            S_ERR: begin
                e_d <= sat_err(d_ref_r, d_meas_r);
                e_q <= sat_err(q_ref_r, q_meas_r);
            end
            S_DP: p_d <= scaled;
            S_QP: p_q <= scaled;
            default: ;
        endcase
    end

    assign bus.vd   = vd_r;
    assign bus.vq   = vq_r;
    assign bus.done = done_r;
    assign bus.busy = (state != S_IDLE);
endmodule

// File: tb/tb_dq_pi_ctrl.sv
// Self-checking bench for dq_pi_ctrl: table of directed vectors plus hand-written handshake/reset sequences.
// Expectations follow the DQ_PI_COND_INT_EN setting of the build.
module tb_dq_pi_ctrl;
    localparam int DW = 18;

    typedef struct {
        string name;
        bit    clr;
        int    d_ref, d_meas, q_ref, q_meas, kp, ki;
        int    exp_vd, exp_vq;
    } vec_t;

    logic clk = 1'b0;
    logic rstb;
    int   n_pass = 0;
    int   n_total = 0;

    dq_pi_ctrl_if #(.D_WIDTH(DW)) bus ();

    dq_pi_ctrl #(.D_WIDTH(DW), .Q_BITS(15), .OUT_LIM(32767), .INT_LIM(32767)) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.d_ref  = DW'(v.d_ref);
        bus.d_meas = DW'(v.d_meas);
        bus.q_ref  = DW'(v.q_ref);
        bus.q_meas = DW'(v.q_meas);
        bus.kp     = DW'(v.kp);
        bus.ki     = DW'(v.ki);
    endtask

    // One start pulse, then latency, outputs, busy and single-cycle done are checked.
    task automatic run_vector(input vec_t v);
        int lat;
        @(negedge clk);
        drive(v);
        bus.clear_int = v.clr;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.clear_int = 1'b0;
        check({v.name, ".busy"}, int'(bus.busy), 1);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({v.name, ".latency"}, lat, 6);
        check({v.name, ".vd"}, int'(bus.vd), v.exp_vd);
        check({v.name, ".vq"}, int'(bus.vq), v.exp_vq);
        check({v.name, ".idle_at_done"}, int'(bus.busy), 0);
        @(negedge clk);
        check({v.name, ".done_width"}, int'(bus.done), 0);
    endtask

    vec_t vecs[$];
    vec_t v;
    int   n_done;
    int   pos[4];
    int   lat;
    int   exp_cond;

    initial begin
        //                name          clr d_ref    d_meas   q_ref    q_meas  kp      ki     vd      vq
        vecs.push_back('{"p_only",      1, 16384,   0,       0,       8192,   16384,  0,     8192,   -4096});
        vecs.push_back('{"int1",        1, 16384,   0,       0,       0,      0,      8192,  4096,   0});
        vecs.push_back('{"int2",        0, 16384,   0,       0,       0,      0,      8192,  8192,   0});
        vecs.push_back('{"int3",        0, 16384,   0,       0,       0,      0,      8192,  12288,  0});
        vecs.push_back('{"int_clr",     1, 16384,   0,       0,       0,      0,      8192,  4096,   0});
        vecs.push_back('{"clamp_pos",   1, 65536,   0,       -65536,  0,      32768,  0,     32767,  -32767});
        vecs.push_back('{"clamp_neg",   1, -65536,  0,       65536,   0,      32768,  0,     -32767, 32767});
        vecs.push_back('{"pin1",        1, 65536,   0,       -65536,  0,      0,      32768, 32767,  -32767});
        vecs.push_back('{"pin2",        0, 65536,   0,       -65536,  0,      0,      32768, 32767,  -32767});
        vecs.push_back('{"pin3",        0, 65536,   0,       -65536,  0,      0,      32768, 32767,  -32767});
        vecs.push_back('{"pin_backoff", 0, 0,       1,       1,       0,      0,      32768, 32766,  -32766});
        vecs.push_back('{"err_sat",     1, 131071,  -131072, -131072, 131071, 32768,  0,     32767,  -32767});
        vecs.push_back('{"floor",       1, 0,       1,       1,       0,      16384,  0,     -1,     0});
        vecs.push_back('{"neg_gain",    1, 16384,   0,       0,       16384,  -16384, -8192, -12288, 12288});
        vecs.push_back('{"small_mix",   1, -7,      0,       7,       0,      3,      5,     -2,     0});

        rstb = 1'b1;
        bus.start = 1'b1;
        bus.clear_int = 1'b0;
        drive('{"zero", 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.vd", int'(bus.vd), 0);
        check("reset.vq", int'(bus.vq), 0);
        check("reset.done", int'(bus.done), 0);
        check("reset.busy_with_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rstb = 1'b0;

        foreach (vecs[i]) run_vector(vecs[i]);

        // start held high for 20 edges: accepted at 0, 7, 14; ignored while busy and in OUT.
        @(negedge clk);
        drive('{"hs", 0, 16384, 0, 0, -16384, 0, 8192, 0, 0});
        bus.clear_int = 1'b1;
        bus.start = 1'b1;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.clear_int = 1'b0;
            if (c == 19) bus.start = 1'b0;
            if (bus.done) begin
                if (n_done < 4) pos[n_done] = c;
                n_done++;
            end
        end
        check("held_start.count", n_done, 3);
        check("held_start.pulse0", pos[0], 6);
        check("held_start.pulse1", pos[1], 13);
        check("held_start.pulse2", pos[2], 20);
        check("held_start.vd", int'(bus.vd), 12288);
        check("held_start.vq", int'(bus.vq), 12288);

        // Reset at cycle 3 of a computation aborts it silently.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        check("abort.busy", int'(bus.busy), 0);
        check("abort.vd", int'(bus.vd), 0);
        check("abort.vq", int'(bus.vq), 0);
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort.no_done", n_done, 0);

        // clear_int raised while busy must not touch the integrators.
        v = '{"cwb_seed", 1, 16384, 0, 0, -16384, 0, 8192, 4096, 4096};
        run_vector(v);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clear_int = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.clear_int = 1'b0;
        check("cwb.latency", lat, 6);
        check("cwb.vd", int'(bus.vd), 8192);
        v = '{"cwb_after", 0, 16384, 0, 0, -16384, 0, 8192, 12288, 12288};
        run_vector(v);

        // Saturated output with a large positive error, then a reversal.
        v = '{"aw1", 1, 65536, 0, 0, 0, 32768, 8192, 32767, 0};
        run_vector(v);
        v.name = "aw2"; v.clr = 1'b0;
        run_vector(v);
        v.name = "aw3";
        run_vector(v);
`ifdef DQ_PI_COND_INT_EN
        exp_cond = -20480;
`else
        exp_cond = 12287;
`endif
        v = '{"aw_reverse", 0, -16384, 0, 0, 0, 32768, 8192, exp_cond, 0};
        run_vector(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule

// File: doc/dq_pi_ctrl.md
Name: dq_pi_ctrl

Overview:
Dual-axis PI current controller for the FOC datapath. It consumes the D/Q current pair and done strobe from the Park stage and produces the voltage commands Vd/Vq for the inverse-Park stage. One shared signed multiplier is time-multiplexed through a sequencer, which keeps DSP use to a single multiplier per instance. Integrators are clamped and persist across updates.

Parameters:
D_WIDTH, 18, width of all signed data, reference, gain and output words
Q_BITS, 15, fractional bits of the fixed-point format (1.0 = 2^Q_BITS)
OUT_LIM, 32767, symmetric clamp on vd/vq (±OUT_LIM)
INT_LIM, 32767, symmetric clamp on each integrator (±INT_LIM)

Ports:
clk  in  1  clock
rstb  in  1  reset; synchronous, active-high (1 = reset)
d_meas  in  D_WIDTH  signed measured D current
q_meas  in  D_WIDTH  signed measured Q current
d_ref  in  D_WIDTH  signed D current setpoint
q_ref  in  D_WIDTH  signed Q current setpoint
kp  in  D_WIDTH  signed proportional gain, Q_BITS fractional
ki  in  D_WIDTH  signed integral gain per update, Q_BITS fractional
start  in  1  new sample valid; connects to the upstream done strobe
clear_int  in  1  zero both integrators
vd  out  D_WIDTH  signed D voltage command
vq  out  D_WIDTH  signed Q voltage command
busy  out  1  high while a computation is in flight
done  out  1  one-cycle pulse when vd/vq update

Behaviour:
- Reset (rstb=1 at a rising edge): vd=0, vq=0, done=0, busy=0, both integrators=0, state=IDLE. Reset takes priority over every other input. Reset mid-computation aborts it with no done pulse.
- States: IDLE, ERR, D_P, D_I, Q_P, Q_I, OUT. Each non-IDLE state lasts exactly 1 cycle, in the order listed. OUT returns to IDLE.
- IDLE with start=1: latch all six data/gain inputs and go to ERR. busy=1 from the next cycle until OUT inclusive.
- start while busy is ignored, with no queuing. start in the OUT cycle is also ignored.
- ERR: e_d = d_ref − d_meas and e_q = q_ref − q_meas. Each is computed at D_WIDTH+1 bits and saturated to the signed D_WIDTH range.
- *_P: p = (kp·e) >>> Q_BITS. The product is 2·D_WIDTH bits and the shift is arithmetic, so the result is floored.
- *_I:
  - i_new = clamp(i_old + ((ki·e) >>> Q_BITS), ±INT_LIM), computed at 2·D_WIDTH bits before clamping.
  - The integrator register is written with i_new.
- OUT: u = clamp(p + i_new, ±OUT_LIM). vd and vq are registered at the end of OUT.
- done=1 for exactly one cycle in the cycle after OUT, coincident with the new vd/vq values.
- Latency: start sampled at edge N gives done high during cycle N+6 (6 clocks). Maximum throughput is one sample per 7 cycles.
- vd/vq hold their value between updates.
- clear_int:
  - Honoured only in IDLE.
  - If start is also high in the same cycle, the integrators are zeroed and the new computation uses i_old = 0.
  - Ignored while busy.
- Gains are signed; negative kp/ki are legal and carry no special handling.

Optional Feature:
DQ_PI_COND_INT_EN
- Defined: conditional-integration anti-windup. The unclamped output u_raw = p + i_old is evaluated in *_I. If |u_raw| > OUT_LIM and e has the same sign as u_raw, the integrator holds i_old. Otherwise it integrates as normal.
- Undefined: the integrator always updates, subject only to the INT_LIM clamp.

Test Plan:
- P only: kp=16384, ki=0, d_ref=16384, d_meas=0, q_ref=0, q_meas=8192, start pulse -> done exactly 6 cycles later, vd=8192, vq=−4096.
- Integrate: kp=0, ki=8192, d_ref=16384, d_meas=0, three starts spaced 7 cycles apart -> vd = 4096, 8192, 12288. Then clear_int + start -> vd=4096.
- Clamps: kp=32768, ki=0, d_ref=65536, d_meas=0 -> vd=32767. Mirror with d_ref=−65536 -> vd=−32767. With kp=0, ki=32768, e=65536, repeated starts -> integrator pinned at 32767.
- Error saturation and rounding:
  - d_ref=131071, d_meas=−131072, kp=32768 -> e=131071, vd=32767.
  - kp=16384, e=−1 -> vd=−1 (floor).
- Handshake: start held high for 20 cycles -> exactly 3 done pulses at cycles 6, 13, 20. Mid-flight rstb=1 at cycle 3 -> no done, vd=vq=0, busy=0.
- DQ_PI_COND_INT_EN defined: kp=32768, ki=8192, e=65536, repeated starts -> vd stays 32767 and the integrator stops growing once saturated. The next sample with e=−16384 drops vd below OUT_LIM immediately.
